// File: rtl/sram_line_burst_adapter.sv
// Cache-line front end for the 32-bit SRAM controller. It splits one refill or
// writeback line into single-word strobes and gathers read words into a line buffer.
module sram_line_burst_adapter #(
    parameter int LINE_WORDS  = 4,
    parameter int ADDR_W      = 18,
    parameter int TIMEOUT_CYC = 31
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_mem_req,
    input  logic                       i_mem_we,
    input  logic [ADDR_W-1:0]          i_mem_addr,
    input  logic [32*LINE_WORDS-1:0]   i_mem_wdata,
    output logic                       o_mem_ready,
    output logic                       o_mem_done,
    output logic                       o_mem_err,
    output logic [32*LINE_WORDS-1:0]   o_mem_rdata,
    output logic [ADDR_W-1:0]          o_sram_addr,
    output logic [31:0]                o_sram_wdata,
    output logic [3:0]                 o_sram_bmask,
    output logic                       o_sram_wren,
    output logic                       o_sram_rden,
    input  logic [31:0]                i_sram_rdata,
    input  logic                       i_sram_ack
);
    // state | meaning
    // IDLE  | ready for a line request
    // ISSUE | one-cycle read/write strobe for word k
    // WAIT  | strobes low, waiting for ack with watchdog running
    // DONE  | one-cycle done pulse, refill line published
    // ERR   | one-cycle watchdog abort pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    localparam int KW  = $clog2(LINE_WORDS);
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(2 * LINE_WORDS - 1);

    state_t                    state;
    logic                      we;
    logic [ADDR_W-1:0]         base;
    logic [32*LINE_WORDS-1:0]  wline;
    logic [32*LINE_WORDS-1:0]  line_buf;
    logic [32*LINE_WORDS-1:0]  buf_upd;
    logic [KW-1:0]             k;
    logic [KW-1:0]             k_nxt;
    logic [WDW-1:0]            wdog;
    logic [ADDR_W-1:0]         base_in;

    assign o_sram_bmask = 4'hF;
    assign k_nxt        = k + KW'(1);
    assign base_in      = i_mem_addr & ALIGN_MASK;

    always_comb begin
        buf_upd = line_buf;
        buf_upd[32*k +: 32] = i_sram_rdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= S_IDLE;
            o_mem_ready  <= 1'b1;
            o_mem_done   <= 1'b0;
            o_mem_err    <= 1'b0;
            o_mem_rdata  <= '0;
            o_sram_addr  <= '0;
            o_sram_wdata <= '0;
            o_sram_wren  <= 1'b0;
            o_sram_rden  <= 1'b0;
            we           <= 1'b0;
            base         <= '0;
            wline        <= '0;
            line_buf     <= '0;
            k            <= '0;
            wdog         <= '0;
        end else begin
            o_mem_done  <= 1'b0;
            o_mem_err   <= 1'b0;
            o_sram_wren <= 1'b0;
            o_sram_rden <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_mem_req) begin
                        we           <= i_mem_we;
                        base         <= base_in;
                        wline        <= i_mem_wdata;
                        k            <= '0;
                        o_sram_addr  <= base_in;
                        o_sram_wdata <= i_mem_wdata[31:0];
                        o_sram_wren  <= i_mem_we;
                        o_sram_rden  <= ~i_mem_we;
                        o_mem_ready  <= 1'b0;
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Down-counter: terminal count zero marks the last allowed wait cycle.
                    wdog  <= WDW'(TIMEOUT_CYC - 1);
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_sram_ack) begin
                        if (!we) begin
                            line_buf <= buf_upd;
                        end
                        if (k == KW'(LINE_WORDS - 1)) begin
                            if (!we) begin
                                o_mem_rdata <= buf_upd;
                            end
                            o_mem_done <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            k            <= k_nxt;
                            o_sram_addr  <= base + ADDR_W'({k_nxt, 1'b0});
                            o_sram_wdata <= wline[32*k_nxt +: 32];
                            o_sram_wren  <= we;
                            o_sram_rden  <= ~we;
                            state        <= S_ISSUE;
                        end
                    end else if (wdog == '0) begin
                        o_mem_err <= 1'b1;
                        state     <= S_ERR;
                    end else begin
                        wdog <= wdog - WDW'(1);
                    end
                end
                S_DONE, S_ERR: begin
                    o_mem_ready <= 1'b1;
                    state       <= S_IDLE;
                end
                default: begin
                    o_mem_ready <= 1'b1;
                    state       <= S_IDLE;
                end
            endcase
        end
    end
endmodule
